// File: rtl/butterfly.sv
// Radix-2 DIT FFT butterfly with a constant complex twiddle W = w_r + j*w_i.
//   out1 = in1 + in2*W,  out2 = in1 - in2*W  (signed complex, wrap-around)
// Two register stages, one sample pair per clock, no backpressure.
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   in_valid              qualifies in1_*/in2_* this cycle
//   in1_r/i, in2_r/i      signed WIDTH-bit complex inputs (in2 is multiplied by W)
//   out_valid             in_valid delayed by two cycles
//   out1_r/i, out2_r/i    sum / difference outputs, low WIDTH bits
module butterfly #(
  parameter int WIDTH     = 16,
  parameter int w_r       = 2,
  parameter int w_i       = 3,
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1_r,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_r,
  input  logic [WIDTH-1:0] in2_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] out1_r,
  output logic [WIDTH-1:0] out1_i,
  output logic [WIDTH-1:0] out2_r,
  output logic [WIDTH-1:0] out2_i
);

  // Full-precision product width: two WIDTH-bit products plus a carry.
  localparam int PW = 2*WIDTH + 1;
  localparam logic signed [PW-1:0] WR = PW'(w_r);
  localparam logic signed [PW-1:0] WI = PW'(w_i);

  // Sign-extend in2 to the product width so the multiply is fully signed.
  logic signed [PW-1:0] a_r, a_i;
  logic signed [PW-1:0] p_r_full, p_i_full;
  logic signed [PW-1:0] p_r, p_i;

  always_comb begin
    a_r      = PW'($signed(in2_r));
    a_i      = PW'($signed(in2_i));
    p_r_full = a_r * WR - a_i * WI;
    p_i_full = a_r * WI + a_i * WR;
    // Arithmetic shift floors toward minus infinity for negative products.
    p_r      = p_r_full >>> FRAC_BITS;
    p_i      = p_i_full >>> FRAC_BITS;
  end

  // Stage 1: scaled product plus in1 delayed to line up with it.
  logic signed [PW-1:0]    s1_p_r, s1_p_i;
  logic signed [WIDTH-1:0] s1_in1_r, s1_in1_i;
  logic [2:1]              vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p_r   <= '0;
      s1_p_i   <= '0;
      s1_in1_r <= '0;
      s1_in1_i <= '0;
    end else begin
      s1_p_r   <= p_r;
      s1_p_i   <= p_i;
      s1_in1_r <= $signed(in1_r);
      s1_in1_i <= $signed(in1_i);
    end
  end

  // Stage 2: add/subtract at full width, keep the low WIDTH bits (wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_r <= '0;
      out1_i <= '0;
      out2_r <= '0;
      out2_i <= '0;
    end else begin
      out1_r <= WIDTH'(PW'(s1_in1_r) + s1_p_r);
      out1_i <= WIDTH'(PW'(s1_in1_i) + s1_p_i);
      out2_r <= WIDTH'(PW'(s1_in1_r) - s1_p_r);
      out2_i <= WIDTH'(PW'(s1_in1_i) - s1_p_i);
    end
  end

  // Valid shift register; data registers load regardless of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[1], in_valid};
  end

  assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_butterfly.sv
// Directed, table-driven bench for butterfly. The main instance uses the
// default twiddle 2+3j; two extra instances share the same inputs to check
// fractional scaling (W=2, FRAC_BITS=1) and floor rounding (W=3+1j, FRAC_BITS=1).
module tb_butterfly;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in1_r = '0, in1_i = '0, in2_r = '0, in2_i = '0;

  logic        ov_a, ov_b, ov_c;
  logic [15:0] a1r, a1i, a2r, a2i;
  logic [15:0] b1r, b1i, b2r, b2i;
  logic [15:0] c1r, c1i, c2r, c2i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  butterfly dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .out_valid(ov_a), .out1_r(a1r), .out1_i(a1i), .out2_r(a2r), .out2_i(a2i)
  );

  butterfly #(.WIDTH(16), .w_r(2), .w_i(0), .FRAC_BITS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .out_valid(ov_b), .out1_r(b1r), .out1_i(b1i), .out2_r(b2r), .out2_i(b2i)
  );

  butterfly #(.WIDTH(16), .w_r(3), .w_i(1), .FRAC_BITS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .out_valid(ov_c), .out1_r(c1r), .out1_i(c1i), .out2_r(c2r), .out2_i(c2i)
  );

  typedef struct {
    logic [15:0] i1r, i1i, i2r, i2i;
    logic [15:0] e1r, e1i, e2r, e2i;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " out_valid"}, {15'd0, ov_a}, 16'd1);
    chk({nm, " out1_r"}, a1r, v.e1r);
    chk({nm, " out1_i"}, a1i, v.e1i);
    chk({nm, " out2_r"}, a2r, v.e2r);
    chk({nm, " out2_i"}, a2i, v.e2i);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in1_r = v.i1r; in1_i = v.i1i; in2_r = v.i2r; in2_i = v.i2i;
    in_valid = vld;
  endtask

  initial begin
    // in1, in2, then expected out1, out2 for W = 2+3j
    tv[0] = '{16'd10, 16'd5, 16'd3, 16'd2, 16'd10, 16'd18, 16'd10, 16'hFFF8};
    tv[1] = '{16'd10, 16'd5, 16'd8, 16'd4, 16'd14, 16'd37, 16'd6,  16'hFFE5};
    tv[2] = '{16'h7FFF, 16'd0, 16'd1, 16'd0, 16'h8001, 16'd3, 16'h7FFD, 16'hFFFD};
    tv[3] = '{16'd0, 16'd0, 16'hFFFD, 16'd0, 16'hFFFA, 16'hFFF7, 16'd6, 16'd9};
    tv[4] = '{16'h8000, 16'd0, 16'hFFFF, 16'd0, 16'h7FFE, 16'hFFFD, 16'h8002, 16'd3};

    // Reset state
    #12;
    chk("reset out_valid", {15'd0, ov_a}, 16'd0);
    chk("reset out1_r", a1r, 16'd0);
    chk("reset out1_i", a1i, 16'd0);
    chk("reset out2_r", a2r, 16'd0);
    chk("reset out2_i", a2i, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Isolated vectors: valid pulse, not valid after one edge, result after two
    for (int k = 0; k < 5; k++) begin
      drive(tv[k], 1'b1);
      @(negedge clk);
      chk($sformatf("vec%0d early valid", k), {15'd0, ov_a}, 16'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk_out($sformatf("vec%0d", k), tv[k]);
      if (k == 3) begin
        // Fractional scaling and floor rounding on the side instances
        chk("frac W2 valid", {15'd0, ov_b}, 16'd1);
        chk("frac W2 out1_r", b1r, 16'hFFFD);
        chk("frac W2 out2_r", b2r, 16'd3);
        chk("frac W2 out1_i", b1i, 16'd0);
        chk("floor W3+j out1_r", c1r, 16'hFFFB);
        chk("floor W3+j out1_i", c1i, 16'hFFFE);
        chk("floor W3+j out2_r", c2r, 16'd5);
        chk("floor W3+j out2_i", c2i, 16'd2);
      end
      @(negedge clk);
      chk($sformatf("vec%0d valid drop", k), {15'd0, ov_a}, 16'd0);
    end

    // Back-to-back: results on consecutive cycles, in order
    drive(tv[0], 1'b1);
    @(negedge clk);
    drive(tv[1], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("b2b first", tv[0]);
    @(negedge clk);
    chk_out("b2b second", tv[1]);
    @(negedge clk);
    chk("b2b valid drop", {15'd0, ov_a}, 16'd0);

    // Reset mid-stream: outputs clear without a clock edge, nothing stale after
    drive(tv[0], 1'b1);
    @(negedge clk);
    drive(tv[1], 1'b1);
    @(negedge clk);
    drive(tv[2], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset valid", {15'd0, ov_a}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {15'd0, ov_a}, 16'd0);
    chk("async reset out1_r", a1r, 16'd0);
    chk("async reset out2_i", a2i, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset stale %0d", k), {15'd0, ov_a}, 16'd0);
    end
    drive(tv[1], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-reset early valid", {15'd0, ov_a}, 16'd0);
    @(negedge clk);
    chk_out("post-reset vec", tv[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
